// File: rtl/exec_core.sv
// exec_core: execute stage -- opcode decode, ALU with registered carry/zero flags, 2^AW x DW data memory.
// Optional ALU_ADC_EN: ADD folds c_in into the sum and carry.
module exec_core #(
    parameter int DW = 8,
    parameter int AW = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    opr,
    input  logic          halt,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] n1,
    input  logic [DW-1:0] rd2,
    input  logic          c_in,
    output logic [5:0]    ctrl,
    output logic [DW-1:0] y,
    output logic          cout,
    output logic          zero,
    output logic [DW-1:0] dout
);
    localparam logic [2:0] OP_NOP = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_AND = 3'd3,
                           OP_OR  = 3'd4, OP_PA  = 3'd5, OP_PB  = 3'd6;

    logic [2:0]    op;
    logic [DW-1:0] n2;
    logic [DW:0]   add_s, sub_s;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_comb begin
        ctrl = 6'h00;
        op   = OP_NOP;
        if (!halt && !rst) begin
            case (opr)
                4'b0000: begin ctrl = 6'h27; op = OP_PB;  end
                4'b0001: begin ctrl = 6'h09; op = OP_PA;  end
                4'b0010: begin ctrl = 6'h27; op = OP_ADD; end
                4'b0011: begin ctrl = 6'h27; op = OP_SUB; end
                4'b0110: begin ctrl = 6'h10; op = OP_NOP; end
                4'b1000: begin ctrl = 6'h04; op = OP_ADD; end
                4'b1001: begin ctrl = 6'h04; op = OP_SUB; end
                4'b1010: begin ctrl = 6'h04; op = OP_AND; end
                4'b1011: begin ctrl = 6'h04; op = OP_OR;  end
                default: begin ctrl = 6'h00; op = OP_NOP; end
            endcase
        end
    end

    assign n2 = ctrl[1] ? dout : rd2;

`ifdef ALU_ADC_EN
    assign add_s = {1'b0, n1} + {1'b0, n2} + {{DW{1'b0}}, c_in};
`else
    logic unused_c_in;
    assign unused_c_in = c_in;
    assign add_s = {1'b0, n1} + {1'b0, n2};
`endif
    // Subtract as n1 + ~n2 + 1 so the carry reads as "no borrow".
    assign sub_s = {1'b0, n1} + {1'b0, ~n2} + {{DW{1'b0}}, 1'b1};

    always_comb begin
        y = op == OP_ADD ? add_s[DW-1:0] :
            op == OP_SUB ? sub_s[DW-1:0] :
            op == OP_AND ? n1 & n2 :
            op == OP_OR  ? n1 | n2 :
            op == OP_PA  ? n1 :
            op == OP_PB  ? n2 : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cout <= 1'b0;
            zero <= 1'b0;
        end else if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_OR) begin
            zero <= y == '0;
            cout <= op == OP_ADD ? add_s[DW] : op == OP_SUB ? sub_s[DW] : 1'b0;
        end
    end

    // Reads are asynchronous; a write lands at the edge, so same-cycle reads see old data.
    always_ff @(posedge clk) begin
        if (ctrl[3])
            mem[addr] <= y;
    end

    assign dout = mem[addr];
endmodule

// File: tb/tb_exec_core.sv
// tb_exec_core: directed plus random instruction stream checked against an opcode-level reference model.
module tb_exec_core;
    logic        clk, rst, halt, c_in;
    logic [3:0]  opr;
    logic [12:0] addr;
    logic [7:0]  n1, rd2, y, dout;
    logic [5:0]  ctrl;
    logic        cout, zero;

    int checks = 0, errors = 0;
    logic [7:0] mem_m [int];
    logic cout_m = 1'b0, zero_m = 1'b0;

    exec_core #(.DW(8), .AW(13)) dut (
        .clk(clk), .rst(rst), .opr(opr), .halt(halt), .addr(addr), .n1(n1),
        .rd2(rd2), .c_in(c_in), .ctrl(ctrl), .y(y), .cout(cout), .zero(zero), .dout(dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] ctrl_of(input logic [3:0] o);
        case (o)
            4'd0, 4'd2, 4'd3:               return 6'h27;
            4'd1:                           return 6'h09;
            4'd6:                           return 6'h10;
            4'd8, 4'd9, 4'd10, 4'd11:       return 6'h04;
            default:                        return 6'h00;
        endcase
    endfunction

    task automatic step(input logic r, input logic [3:0] o, input logic h, input logic [12:0] a,
                        input logic [7:0] x, input logic [7:0] b, input logic ci);
        logic [5:0] ec;
        logic [7:0] n2e, ye;
        int s;
        bit live, flag_op;
        rst = r; opr = o; halt = h; addr = a; n1 = x; rd2 = b; c_in = ci;
        #2;
        live = !r && !h;
        ec = live ? ctrl_of(o) : 6'h00;
        n2e = ec[1] ? (mem_m.exists(int'(a)) ? mem_m[int'(a)] : 8'hxx) : b;
        s = 0;
`ifdef ALU_ADC_EN
        s = int'(ci);
`endif
        ye = 8'h00;
        flag_op = 0;
        if (live) begin
            case (o)
                4'd0: ye = n2e;
                4'd1: ye = x;
                4'd2, 4'd8: begin s = s + int'(x) + int'(n2e); ye = s[7:0]; flag_op = 1; end
                4'd3, 4'd9: begin ye = x - n2e; flag_op = 1; end
                4'd10: begin ye = x & n2e; flag_op = 1; end
                4'd11: begin ye = x | n2e; flag_op = 1; end
                default: ye = 8'h00;
            endcase
        end
        chk("ctrl", {2'b00, ctrl}, {2'b00, ec});
        chk("y", y, ye);
        if (mem_m.exists(int'(a))) chk("dout", dout, mem_m[int'(a)]);
        @(posedge clk);
        if (r) begin
            cout_m = 0; zero_m = 0;
        end else if (flag_op) begin
            zero_m = ye == 8'h00;
            cout_m = (o == 4'd2 || o == 4'd8) ? s > 255 : (o == 4'd3 || o == 4'd9) ? x >= n2e : 1'b0;
        end
        if (ec[3]) mem_m[int'(a)] = ye;
        #1;
        chk("cout", {7'd0, cout}, {7'd0, cout_m});
        chk("zero", {7'd0, zero}, {7'd0, zero_m});
    endtask

    initial begin
        logic [3:0] o;
        // reset with STA presented: no write, flags cleared
        step(1, 4'b0001, 0, 13'h0005, 8'h99, 8'h00, 0);
        step(1, 4'b0001, 0, 13'h0005, 8'h99, 8'h00, 0);
        // STA then LDA from the same address
        step(0, 4'b0001, 0, 13'h1ABC, 8'h5A, 8'h00, 0);
        step(0, 4'b0000, 0, 13'h1ABC, 8'h11, 8'h00, 0);
        // ADDR overflow to zero (ADC variant gives 0x01)
        step(0, 4'b1000, 0, 13'h0000, 8'hF0, 8'h10, 1);
        // SUBM with borrow, then exact
        step(0, 4'b0001, 0, 13'h0005, 8'h03, 8'h00, 0);
        step(0, 4'b0011, 0, 13'h0005, 8'h02, 8'h00, 0);
        step(0, 4'b0011, 0, 13'h0005, 8'h03, 8'h00, 0);
        // halt suppresses decode; JMP
        step(0, 4'b0010, 1, 13'h0005, 8'h01, 8'h01, 0);
        step(0, 4'b0110, 0, 13'h0005, 8'h01, 8'h01, 0);
        // ANDR to zero, then undefined opcode holds flags
        step(0, 4'b1010, 0, 13'h0005, 8'h0F, 8'hF0, 0);
        step(0, 4'b1111, 0, 13'h0005, 8'h00, 8'h00, 0);
        // reset mid-STA must not write mem[5]
        step(1, 4'b0001, 0, 13'h0005, 8'h77, 8'h00, 0);
        step(0, 4'b0000, 0, 13'h0005, 8'h00, 8'h00, 0);
        // seed a small address window so random memory reads are defined
        for (int i = 0; i < 16; i++)
            step(0, 4'b0001, 0, 13'(i), 8'($urandom), 8'h00, 0);
        for (int i = 0; i < 400; i++) begin
            o = 4'($urandom);
            step($urandom_range(0, 30) == 0, o, $urandom_range(0, 7) == 0, 13'($urandom_range(0, 15)),
                 8'($urandom), 8'($urandom), 1'($urandom));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
